// File: rtl/tile_fetch_pkg.sv
// Shared types and tile geometry for the tile fetch scheduler.
package tile_fetch_pkg;
  localparam int TILE_W      = 20;
  localparam int TILE_H      = 20;
  localparam int TILE_PIX    = 400;
  localparam int TILE_ADDR_W = 9;

  typedef logic [11:0] color_t;
  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} tf_state_t;

  // Requester-id width; a lone requester still needs a 1-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tile_fetch_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at/after the pointer wins.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_id,
  output logic               o_any
);
  int  w_idx;
  logic w_hit;

  // Scan from the pointer with wraparound; only the first hit is granted.
  always_comb begin
    o_grant = '0;
    o_id    = '0;
    o_any   = 1'b0;
    w_idx   = 0;
    w_hit   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx          = (int'(i_ptr) + i) % NUM_REQ;
      w_hit          = !o_any && i_req[w_idx];
      o_grant[w_idx] = o_grant[w_idx] | w_hit;
      o_id           = w_hit ? ID_W'(w_idx) : o_id;
      o_any          = o_any | w_hit;
    end
  end
endmodule

// File: rtl/tile_fetch_scheduler.sv
// Round-robin tile-row fetcher: walks one 20-pixel ROM row into the line buffer, skipping the colour key.
// Optional TILE_FETCH_HFLIP_EN adds per-requester horizontal mirroring.
module tile_fetch_scheduler
  import tile_fetch_pkg::*;
#(
  parameter int     NUM_REQ     = 2,
  parameter int     LINE_W      = 640,
  parameter color_t TRANSPARENT = 12'h808,
  localparam int    LB_W        = $clog2(LINE_W),
  localparam int    ID_W        = id_width(NUM_REQ)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*5-1:0]   req_row,
  input  logic [NUM_REQ*10-1:0]  req_x,
`ifdef TILE_FETCH_HFLIP_EN
  input  logic [NUM_REQ-1:0]     req_flip,
`endif
  output logic [TILE_ADDR_W-1:0] rom_addr,
  input  color_t                 rom_color,
  output logic                   lb_we,
  output logic [LB_W-1:0]        lb_addr,
  output color_t                 lb_data,
  output logic                   busy,
  output logic                   done,
  output logic [ID_W-1:0]        done_id
);
  tf_state_t               r_state;
  logic [ID_W-1:0]         r_ptr, r_id, r_done_id;
  logic [4:0]              r_row, r_col;
  logic [9:0]              r_x;
  logic                    r_lb_we, r_busy, r_done;
  logic [LB_W-1:0]         r_lb_addr;
  color_t                  r_lb_data;
  logic [NUM_REQ-1:0]      w_req, w_grant;
  logic [ID_W-1:0]         w_id, w_next_ptr;
  logic                    w_any, w_row_ok, w_last, w_in_line;
  logic [4:0]              w_sel_row, w_col_eff;
  logic [9:0]              w_sel_x;
  logic [10:0]             w_sum;
  logic [TILE_ADDR_W-1:0]  w_rom_idx;
`ifdef TILE_FETCH_HFLIP_EN
  logic                    r_flip, w_sel_flip;
`endif

  // Arbitration is only offered while idle and out of reset.
  assign w_req = (r_state == IDLE && !Reset) ? req_valid : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_id    (w_id),
    .o_any   (w_any)
  );

  // Grant is one-hot, so AND-OR muxing picks exactly the winner's fields.
  always_comb begin
    w_sel_row  = 5'd0;
    w_sel_x    = 10'd0;
`ifdef TILE_FETCH_HFLIP_EN
    w_sel_flip = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_row  = w_sel_row | (req_row[i*5 +: 5] & {5{w_grant[i]}});
      w_sel_x    = w_sel_x | (req_x[i*10 +: 10] & {10{w_grant[i]}});
`ifdef TILE_FETCH_HFLIP_EN
      w_sel_flip = w_sel_flip | (req_flip[i] & w_grant[i]);
`endif
    end
  end

`ifdef TILE_FETCH_HFLIP_EN
  assign w_col_eff = r_flip ? (5'd19 - r_col) : r_col;
`else
  assign w_col_eff = r_col;
`endif

  assign w_next_ptr = (w_id == ID_W'(NUM_REQ - 1)) ? '0 : w_id + ID_W'(1);
  assign w_row_ok   = (r_row < 5'(TILE_H));
  assign w_last     = (r_col == 5'(TILE_W - 1));
  // 11-bit sum so a tile hanging off the right edge clips instead of wrapping.
  assign w_sum      = {1'b0, r_x} + {6'd0, r_col};
  assign w_in_line  = (w_sum < 11'(LINE_W));
  assign w_rom_idx  = ({4'd0, r_row} * 9'(TILE_W)) + {4'd0, w_col_eff};

  assign req_ready = w_grant;
  assign rom_addr  = (r_state == FETCH && w_row_ok) ? w_rom_idx : '0;
  assign lb_we     = r_lb_we;
  assign lb_addr   = r_lb_addr;
  assign lb_data   = r_lb_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign done_id   = r_done_id;

  // Fetch FSM; line-buffer port and status flags are registered here.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_row     <= 5'd0;
      r_col     <= 5'd0;
      r_x       <= 10'd0;
      r_lb_we   <= 1'b0;
      r_lb_addr <= '0;
      r_lb_data <= 12'h000;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= '0;
`ifdef TILE_FETCH_HFLIP_EN
      r_flip    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_lb_we   <= 1'b0;
          r_done    <= 1'b0;
          r_done_id <= '0;
          if (w_any) begin
            r_id    <= w_id;
            r_row   <= w_sel_row;
            r_x     <= w_sel_x;
            r_col   <= 5'd0;
            r_ptr   <= w_next_ptr;
            r_busy  <= 1'b1;
            r_state <= FETCH;
`ifdef TILE_FETCH_HFLIP_EN
            r_flip  <= w_sel_flip;
`endif
          end else begin
            r_busy <= 1'b0;
          end
        end
        FETCH: begin
          r_busy <= 1'b1;
          if (!w_row_ok) begin
            r_lb_we   <= 1'b0;
            r_done    <= 1'b1;
            r_done_id <= r_id;
            r_state   <= IDLE;
          end else begin
            r_lb_we   <= (rom_color != TRANSPARENT) && w_in_line;
            r_lb_addr <= LB_W'(w_sum);
            r_lb_data <= rom_color;
            r_col     <= r_col + 5'd1;
            if (w_last) begin
              r_done    <= 1'b1;
              r_done_id <= r_id;
              r_state   <= IDLE;
            end else begin
              r_done    <= 1'b0;
              r_done_id <= '0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tile_fetch_scheduler.sv
// Randomised bench for tile_fetch_scheduler: a cycle-schedule reference model predicts every output.
module tb_tile_fetch_scheduler;
  localparam int NUM_REQ = 2;
  localparam int LINE_W  = 640;
  localparam int NCYC    = 4096;

  logic                  Clk = 1'b0;
  logic                  Reset;
  logic [NUM_REQ-1:0]    req_valid, req_ready;
  logic [NUM_REQ*5-1:0]  req_row;
  logic [NUM_REQ*10-1:0] req_x;
  logic [8:0]            rom_addr;
  logic [11:0]           rom_color;
  logic                  lb_we, busy, done;
  logic [9:0]            lb_addr;
  logic [11:0]           lb_data;
  logic [0:0]            done_id;
`ifdef TILE_FETCH_HFLIP_EN
  logic [NUM_REQ-1:0]    req_flip;
`endif

  logic [11:0] rom_mem [0:511];
  assign rom_color = rom_mem[rom_addr];

  always #5 Clk = ~Clk;

  tile_fetch_scheduler dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .req_x(req_x),
`ifdef TILE_FETCH_HFLIP_EN
    .req_flip(req_flip),
`endif
    .rom_addr(rom_addr), .rom_color(rom_color), .lb_we(lb_we), .lb_addr(lb_addr),
    .lb_data(lb_data), .busy(busy), .done(done), .done_id(done_id)
  );

  // expected outputs per absolute cycle
  bit exp_we [NCYC];  int exp_addr [NCYC]; int exp_data [NCYC];
  bit exp_done [NCYC]; int exp_id [NCYC]; bit exp_busy [NCYC];
  bit exp_rv [NCYC];  int exp_ra [NCYC];

  int n_err = 0, n_chk = 0;
  int cyc = 0, free_cyc = 0, m_ptr = 0, last_acc = 0, nw = 0, mode = 0;
  bit rst_req = 1'b0;
  bit pend [NUM_REQ];
  logic [4:0] prow [NUM_REQ];
  logic [9:0] px [NUM_REQ];
  bit pflip [NUM_REQ];
  int obs_acc [$];
  int obs_cyc [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic issue(input int i, input int row, input int x, input bit f);
    pend[i] = 1'b1; prow[i] = 5'(row); px[i] = 10'(x); pflip[i] = f;
  endtask

  function automatic logic [11:0] rand_color();
    logic [11:0] c;
    c = 12'($urandom);
    if (c == 12'h808) c = 12'h123;
    return c;
  endfunction

  // Predicted consequences of accepting a request in cycle t.
  task automatic schedule(input int id, input int row, input int x, input bit f, input int t);
    int src, a;
    if (row < 20) begin
      for (int k = 0; k < 20; k++) begin
        src = f ? 19 - k : k;
        a = row * 20 + src;
        exp_rv[t+1+k] = 1'b1; exp_ra[t+1+k] = a;
        if (rom_mem[a] != 12'h808 && x + k < LINE_W) begin
          exp_we[t+2+k] = 1'b1; exp_addr[t+2+k] = x + k; exp_data[t+2+k] = int'(rom_mem[a]);
        end
      end
      for (int c = t + 1; c <= t + 21; c++) exp_busy[c] = 1'b1;
      exp_done[t+21] = 1'b1; exp_id[t+21] = id; free_cyc = t + 21;
    end else begin
      exp_busy[t+1] = 1'b1; exp_busy[t+2] = 1'b1;
      exp_done[t+2] = 1'b1; exp_id[t+2] = id; free_cyc = t + 2;
    end
  endtask

  task automatic gen();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mode == 1 && !pend[i]) issue(i, $urandom_range(0, 19), $urandom_range(0, 639), 1'b0);
      else if (mode == 2) begin
        if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(0, 3) == 0)
          issue(i, $urandom_range(0, 23),
                ($urandom_range(0, 2) == 0) ? $urandom_range(600, 1023) : $urandom_range(0, 639),
                1'($urandom));
      end
    end
  endtask

  task automatic step();
    logic [NUM_REQ-1:0] expg;
    int gid, oid, j;
    bit rnd_rst;
    @(negedge Clk);
    cyc++;
    check_eq("lb_we", lb_we, exp_we[cyc]);
    if (exp_we[cyc]) begin
      check_eq("lb_addr", lb_addr, exp_addr[cyc]);
      check_eq("lb_data", lb_data, exp_data[cyc]);
    end
    check_eq("done", done, exp_done[cyc]);
    if (exp_done[cyc]) check_eq("done_id", done_id, exp_id[cyc]);
    check_eq("busy", busy, exp_busy[cyc]);
    if (exp_rv[cyc]) check_eq("rom_addr", rom_addr, exp_ra[cyc]);
    if (lb_we) nw++;
    gen();
    rnd_rst = (mode == 2) && ($urandom_range(0, 299) == 0);
    Reset = rst_req | rnd_rst;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = pend[i];
      req_row[i*5 +: 5] = prow[i];
      req_x[i*10 +: 10] = px[i];
`ifdef TILE_FETCH_HFLIP_EN
      req_flip[i] = pflip[i];
`endif
    end
    #1;
    expg = '0; gid = -1; oid = -1;
    if (!Reset && cyc >= free_cyc) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = (m_ptr + k) % NUM_REQ;
        if (gid < 0 && req_valid[j]) begin expg[j] = 1'b1; gid = j; end
      end
    end
    check_eq("req_ready", req_ready, expg);
    for (int i = 0; i < NUM_REQ; i++) if (req_valid[i] && req_ready[i]) oid = i;
    if (oid >= 0) begin obs_acc.push_back(oid); obs_cyc.push_back(cyc); end
    if (Reset) begin
      for (int c = cyc + 1; c < cyc + 30; c++) begin
        exp_we[c] = 0; exp_done[c] = 0; exp_busy[c] = 0; exp_rv[c] = 0;
      end
      free_cyc = cyc + 1; m_ptr = 0;
    end else if (gid >= 0) begin
`ifdef TILE_FETCH_HFLIP_EN
      schedule(gid, int'(prow[gid]), int'(px[gid]), pflip[gid], cyc);
`else
      schedule(gid, int'(prow[gid]), int'(px[gid]), 1'b0, cyc);
`endif
      m_ptr = (gid + 1) % NUM_REQ; last_acc = cyc; pend[gid] = 1'b0;
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    int t;
    for (int a = 0; a < 512; a++) rom_mem[a] = rand_color();
    for (int i = 0; i < NUM_REQ; i++) begin pend[i] = 0; prow[i] = 0; px[i] = 0; pflip[i] = 0; end
    Reset = 1'b1; req_valid = '1; req_row = '0; req_x = '0;
`ifdef TILE_FETCH_HFLIP_EN
    req_flip = '0;
`endif
    repeat (3) @(negedge Clk);
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_we", lb_we, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_addr", lb_addr, 0);
    check_eq("rst_rom", rom_addr, 0);
    Reset = 1'b0; req_valid = '0;

    // both requesters continuously valid: strict alternation, 21 cycles apart
    obs_acc.delete(); obs_cyc.delete();
    mode = 1; repeat (110) step(); mode = 0; drain(25);
    check_eq("t3_count", (obs_acc.size() >= 5) ? 1 : 0, 1);
    for (int k = 0; k < obs_acc.size() && k < 5; k++) begin
      check_eq("t3_order", obs_acc[k], k % 2);
      if (k > 0) check_eq("t3_gap", obs_cyc[k] - obs_cyc[k-1], 21);
    end

    nw = 0; issue(0, 0, 100, 0); repeat (25) step();
    check_eq("t1_writes", nw, 20);
    rom_mem[3] = 12'h808;
    nw = 0; issue(0, 0, 200, 0); repeat (25) step();
    check_eq("t2_writes", nw, 19);
    nw = 0; issue(0, 19, 630, 0); repeat (25) step();
    check_eq("t4_writes", nw, 10);

    // reset during column 7, then req0 must win first
    issue(0, 5, 0, 0); step(); t = last_acc;
    while (cyc < t + 7) step();
    rst_req = 1'b1; step(); rst_req = 1'b0; step();
    check_eq("t5_we", lb_we, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_done", done, 0);
    obs_acc.delete(); obs_cyc.delete();
    issue(0, 2, 40, 0); issue(1, 3, 300, 0); step();
    check_eq("t5_acc", obs_acc.size(), 1);
    if (obs_acc.size() > 0) check_eq("t5_first", obs_acc[0], 0);
    repeat (50) step();

    nw = 0; issue(1, 20, 10, 0); repeat (6) step();
    check_eq("t6_writes", nw, 0);
`ifdef TILE_FETCH_HFLIP_EN
    issue(0, 1, 0, 1); repeat (25) step();
`endif

    for (int a = 0; a < 512; a++) rom_mem[a] = ($urandom_range(0, 7) == 0) ? 12'h808 : rand_color();
    mode = 2; repeat (1500) step(); mode = 0; drain(30);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
